// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition encodings, flag indices and condition evaluation
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // NV reports fail here; the top decides its meaning from a parameter.
  function automatic logic cond_check(cond_e cond, logic [3:0] flags);
    logic n, z, c, v, p;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      EQ:      p = z;
      NE:      p = !z;
      CS:      p = c;
      CC:      p = !c;
      MI:      p = n;
      PL:      p = !n;
      VS:      p = v;
      VC:      p = !v;
      HI:      p = c & !z;
      LS:      p = !c | z;
      GE:      p = (n == v);
      LT:      p = (n != v);
      GT:      p = !z & (n == v);
      LE:      p = z | (n != v);
      AL:      p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register, condition check, commit strobes and perf counters
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit COND_NV_EXEC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             InstrValid,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  logic commit;

  // Evaluated against the registered flags only; no bypass from ALUFlags.
  always_comb begin
    CondEx = cond_check(cond_e'(Cond), Flags);
    if (cond_e'(Cond) == NV) begin
      CondEx = COND_NV_EXEC;
    end
  end

  assign commit = CondEx & InstrValid;

  assign PCSrc    = PCS & commit & !reset;
  assign RegWrite = RegW & !NoWrite & commit & !reset;
  assign MemWrite = MemW & commit & !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (FlagW[1] && commit) begin
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (FlagW[0] && commit) begin
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_exec_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (CntClr),
    .inc   (InstrValid & CondEx),
    .count (ExecCnt)
  );

  sat_counter #(.W(CNT_W)) u_skip_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (CntClr),
    .inc   (InstrValid & !CondEx),
    .count (SkipCnt)
  );

endmodule
